// File: rtl/stack_pkg.sv
// Shared defaults and controller op codes for the hardware data stack.
package stack_pkg;

    localparam int unsigned STACK_WIDTH = 16;
    localparam int unsigned STACK_DEPTH = 16;

    // Controller drives {pop, push} with these codes
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // Index width for the (depth-1)-entry array below TOS; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage for the stack entries below TOS: (DEPTH-1) x WIDTH, negedge write, async read.
// DATA_STACK_NOS_EN adds a second read port used to refill the next-on-stack register.
module stack_mem
    import stack_pkg::*;
#(
    parameter  int unsigned WIDTH = STACK_WIDTH,
    parameter  int unsigned DEPTH = STACK_DEPTH,
    localparam int unsigned IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
`ifdef DATA_STACK_NOS_EN
    input  logic [IDX_W-1:0] rd2_idx,
    output logic [WIDTH-1:0] rd2_data,
`endif
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH-1];

    always_ff @(negedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

`ifdef DATA_STACK_NOS_EN
    assign rd2_data = mem_q[rd2_idx];
`endif

endmodule

// File: rtl/data_stack.sv
// LIFO data stack feeding the datapath: registered TOS, depth count, sticky error flags.
// Optional DATA_STACK_NOS_EN adds a registered next-on-stack output (nos).
module data_stack
    import stack_pkg::*;
#(
    parameter  int unsigned WIDTH = STACK_WIDTH,
    parameter  int unsigned DEPTH = STACK_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] tos,
`ifdef DATA_STACK_NOS_EN
    output logic [WIDTH-1:0] nos,
`endif
    output logic [CNT_W-1:0] depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [1:0]       op;
    logic             is_empty, is_full;
    logic             mem_we;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [WIDTH-1:0] rd_data;
`ifdef DATA_STACK_NOS_EN
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [IDX_W-1:0] rd2_idx;
    logic [WIDTH-1:0] rd2_data;
`endif

    assign op       = {pop, push};
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == CNT_W'(DEPTH));

    // Old TOS spills to depth-1; the entry under TOS sits at depth-2
    assign wr_idx = IDX_W'(depth_q - CNT_W'(1));
    assign rd_idx = IDX_W'(depth_q - CNT_W'(2));
`ifdef DATA_STACK_NOS_EN
    assign rd2_idx = IDX_W'(depth_q - CNT_W'(3));
`endif

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .wr_en    (mem_we),
        .wr_idx   (wr_idx),
        .wr_data  (tos_q),
        .rd_idx   (rd_idx),
`ifdef DATA_STACK_NOS_EN
        .rd2_idx  (rd2_idx),
        .rd2_data (rd2_data),
`endif
        .rd_data  (rd_data)
    );

    // Op decode and next-state; an error raised this cycle overrides clr_err
    always_comb begin
        tos_d   = tos_q;
        depth_d = depth_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        mem_we  = 1'b0;
`ifdef DATA_STACK_NOS_EN
        nos_d   = nos_q;
`endif
        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = ~is_empty;
                    tos_d   = w_data;
                    depth_d = depth_q + CNT_W'(1);
`ifdef DATA_STACK_NOS_EN
                    nos_d   = tos_q;
`endif
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else if (depth_q >= CNT_W'(2)) begin
                    tos_d   = rd_data;
                    depth_d = depth_q - CNT_W'(1);
`ifdef DATA_STACK_NOS_EN
                    nos_d   = (depth_q >= CNT_W'(3)) ? rd2_data : '0;
`endif
                end else begin
                    tos_d   = '0;
                    depth_d = '0;
`ifdef DATA_STACK_NOS_EN
                    nos_d   = '0;
`endif
                end
            end
            OP_REPL: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    tos_d = w_data;
                end
            end
            default: begin
            end
        endcase
    end

    // State updates on the datapath register write edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            tos_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef DATA_STACK_NOS_EN
            nos_q   <= '0;
`endif
        end else begin
            tos_q   <= tos_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef DATA_STACK_NOS_EN
            nos_q   <= nos_d;
`endif
        end
    end

    assign tos       = tos_q;
    assign depth     = depth_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
`ifdef DATA_STACK_NOS_EN
    assign nos       = nos_q;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack; nos checks compile in when DATA_STACK_NOS_EN is defined.
module tb_data_stack;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] w_data = '0;
    logic [WIDTH-1:0] tos;
    logic [CNT_W-1:0] depth;
    logic             empty, full, overflow, underflow;
`ifdef DATA_STACK_NOS_EN
    logic [WIDTH-1:0] nos;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .w_data    (w_data),
        .tos       (tos),
`ifdef DATA_STACK_NOS_EN
        .nos       (nos),
`endif
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one op between edges, let the negedge apply it, sample 1ns later
    task automatic do_op(input logic ps, input logic pp, input logic cl, input logic [WIDTH-1:0] d);
        @(posedge clk);
        push = ps; pop = pp; clr_err = cl; w_data = d;
        @(negedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] e_tos, input int e_depth,
                               input logic e_ovf, input logic e_unf);
        check({tag, ".tos"}, 32'(tos), 32'(e_tos));
        check({tag, ".depth"}, 32'(depth), 32'(e_depth));
        check({tag, ".empty"}, 32'(empty), 32'(e_depth == 0));
        check({tag, ".full"}, 32'(full), 32'(e_depth == DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(e_unf));
    endtask

    initial begin
        #3;
        check_state("rst0", 16'h0000, 0, 1'b0, 1'b0);
        #4;
        reset = 1'b0;

        // 1: mid-cycle reset with depth 3
        do_op(1, 0, 0, 16'hA001);
        do_op(1, 0, 0, 16'hA002);
        do_op(1, 0, 0, 16'hA003);
        do_op(0, 1, 0, 16'h0000);
        do_op(0, 1, 0, 16'h0000);
        do_op(0, 1, 0, 16'h0000);
        do_op(0, 1, 0, 16'h0000);
        check("pre_rst.unf", 32'(underflow), 32'd1);
        do_op(1, 0, 0, 16'hA001);
        do_op(1, 0, 0, 16'hA002);
        do_op(1, 0, 0, 16'hA003);
        check("pre_rst.depth", 32'(depth), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_state("midrst", 16'h0000, 0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;

        // 2: push three, pop three
        do_op(1, 0, 0, 16'h1111); check_state("p1", 16'h1111, 1, 0, 0);
        do_op(1, 0, 0, 16'h2222); check_state("p2", 16'h2222, 2, 0, 0);
        do_op(1, 0, 0, 16'h3333); check_state("p3", 16'h3333, 3, 0, 0);
        do_op(0, 1, 0, 16'h0000); check_state("q1", 16'h2222, 2, 0, 0);
        do_op(0, 1, 0, 16'h0000); check_state("q2", 16'h1111, 1, 0, 0);
        do_op(0, 1, 0, 16'h0000); check_state("q3", 16'h0000, 0, 0, 0);

        // 3: fill, overflow, then drain checking every entry
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1, 0, 0, 16'(16'h0100 + i));
        end
        check_state("fill", 16'h010F, DEPTH, 0, 0);
`ifdef DATA_STACK_NOS_EN
        check("fill.nos", 32'(nos), 32'h010E);
`endif
        do_op(1, 0, 0, 16'hBEEF);
        check_state("ovf", 16'h010F, DEPTH, 1, 0);
        do_op(0, 1, 0, 16'h0000);
        check_state("ovf_pop", 16'h010E, DEPTH - 1, 1, 0);
`ifdef DATA_STACK_NOS_EN
        check("ovf_pop.nos", 32'(nos), 32'h010D);
`endif
        do_op(0, 0, 0, 16'h0000);
        check("ovf_hold", 32'(overflow), 32'd1);
        do_op(0, 0, 1, 16'h0000);
        check("ovf_clr", 32'(overflow), 32'd0);
        for (int i = DEPTH - 2; i >= 1; i--) begin
            do_op(0, 1, 0, 16'h0000);
            check("drain.tos", 32'(tos), 32'(16'h0100 + i - 1));
        end
        check_state("drain1", 16'h0100, 1, 0, 0);
        do_op(0, 1, 0, 16'h0000);
        check_state("drain0", 16'h0000, 0, 0, 0);

        // 4: underflow on empty, replace on empty
        do_op(0, 1, 0, 16'h0000);
        check_state("unf", 16'h0000, 0, 0, 1);
        do_op(1, 1, 0, 16'h1234);
        check_state("unf_repl", 16'h0000, 0, 0, 1);
        do_op(0, 1, 1, 16'h0000);
        check("unf_clr_set", 32'(underflow), 32'd1);
        do_op(0, 0, 1, 16'h0000);
        check("unf_clr", 32'(underflow), 32'd0);

        // 5: replace at depth 2
        do_op(1, 0, 0, 16'h00AA);
        do_op(1, 0, 0, 16'h00BB);
        do_op(1, 1, 0, 16'h00CC);
        check_state("repl", 16'h00CC, 2, 0, 0);
`ifdef DATA_STACK_NOS_EN
        check("repl.nos", 32'(nos), 32'h00AA);
`endif
        do_op(0, 1, 0, 16'h0000);
        check_state("repl_pop", 16'h00AA, 1, 0, 0);
        do_op(0, 1, 0, 16'h0000);
        check_state("repl_pop2", 16'h0000, 0, 0, 0);

        // 6: nos tracking and clr_err racing an overflow push
        do_op(1, 0, 0, 16'h0005);
`ifdef DATA_STACK_NOS_EN
        check("nos1", 32'(nos), 32'h0000);
`endif
        do_op(1, 0, 0, 16'h0007);
        check("nos_tos", 32'(tos), 32'h0007);
`ifdef DATA_STACK_NOS_EN
        check("nos2", 32'(nos), 32'h0005);
`endif
        do_op(0, 1, 0, 16'h0000);
        check("nos_pop.tos", 32'(tos), 32'h0005);
`ifdef DATA_STACK_NOS_EN
        check("nos_pop", 32'(nos), 32'h0000);
`endif
        for (int i = 1; i < DEPTH; i++) begin
            do_op(1, 0, 0, 16'(16'h0200 + i));
        end
        check("full2", 32'(full), 32'd1);
        do_op(1, 0, 1, 16'hDEAD);
        check_state("clr_vs_ovf", 16'h020F, DEPTH, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
